// File: rtl/conv_sequencer.sv
// conv_sequencer: frame sequencer for an external KxK streaming convolver.
// Loads K*K weights, clears the convolver, streams an NxN raster frame into
// it, forwards its results through a ready/valid port and pulses done.
//
// Ports:
//   clk, global_rst_n          clock and synchronous active-low reset
//   start, abort               one-cycle frame begin / cancel requests
//   wt_valid/wt_ready/wt_data  serial weight stream (beat i -> tap i)
//   act_valid/act_ready/act_data raster-order pixel stream
//   conv_ce/conv_rst/conv_act/conv_wt  convolver drive
//   conv_op/conv_valid         convolver result
//   res_valid/res_ready/res_data result stream
//   busy, done                 frame active / completion pulse
//   perf_cycles, perf_stalls   only with CONV_SEQ_PERF_EN defined
//
// Optional feature macro: CONV_SEQ_PERF_EN (saturating performance counters).
module conv_sequencer #(
    parameter int unsigned N  = 10,
    parameter int unsigned K  = 3,
    parameter int unsigned DW = 16
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [DW-1:0]     wt_data,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [DW-1:0]     act_data,
    output logic              conv_ce,
    output logic              conv_rst,
    output logic [DW-1:0]     conv_act,
    output logic [K*K*DW-1:0] conv_wt,
    input  logic [DW-1:0]     conv_op,
    input  logic              conv_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic              busy,
    output logic              done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam int unsigned TAPS = K * K;
    localparam int unsigned NPIX = N * N;
    localparam int unsigned NRES = (N - K + 1) * (N - K + 1);
    localparam int unsigned WCW  = $clog2(TAPS + 1);
    localparam int unsigned PCW  = $clog2(NPIX + 1);
    localparam int unsigned RCW  = $clog2(NRES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WCW-1:0]   wt_cnt;
    logic [PCW-1:0]   pix_cnt;
    logic [RCW-1:0]   res_cnt;
    logic             ce_d;
    logic             skid_valid;
    logic [DW-1:0]    skid_data;

    logic wt_fire;
    logic res_fire;
    logic pix_last;
    logic res_last;
    logic abort_hit;
    logic capture;

    // Handshake decode; act_ready must react to res_ready in the same cycle.
    assign act_ready = (state_q == STREAM) && !(res_valid && !res_ready);
    assign conv_ce   = act_valid & act_ready;
    assign conv_act  = act_data;
    assign wt_fire   = wt_valid & wt_ready;
    assign res_fire  = res_valid & res_ready;
    assign pix_last  = conv_ce && (pix_cnt == PCW'(NPIX - 1));
    assign res_last  = res_fire && (res_cnt == RCW'(NRES - 1));
    assign abort_hit = abort && (state_q != IDLE);
    // Convolver output belongs to the pixel clocked in on the previous cycle.
    assign capture   = ce_d & conv_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = LOAD_W;
                LOAD_W:  if (wt_fire && (wt_cnt == WCW'(TAPS - 1))) state_d = CLEAR;
                CLEAR:   state_d = STREAM;
                STREAM:  if (pix_last) state_d = DRAIN;
                DRAIN:   if (res_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered control outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wt_ready <= 1'b0;
            conv_rst <= 1'b1;
        end else begin
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            wt_ready <= (state_d == LOAD_W);
            conv_rst <= (state_d == CLEAR) || abort_hit;
        end
    end

    // Weight, pixel and result counters; cleared at frame end or abort.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            wt_cnt  <= '0;
            pix_cnt <= '0;
            res_cnt <= '0;
        end else if (abort_hit || (state_q == DONE)) begin
            wt_cnt  <= '0;
            pix_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (wt_fire)  wt_cnt  <= wt_cnt + WCW'(1);
            if (conv_ce)  pix_cnt <= pix_cnt + PCW'(1);
            if (res_fire) res_cnt <= res_cnt + RCW'(1);
        end
    end

    // Weight register file; kept across frames so it can be reused.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            conv_wt <= '0;
        end else begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                if (wt_fire && (wt_cnt == WCW'(i))) begin
                    conv_wt[i*DW +: DW] <= wt_data;
                end
            end
        end
    end

    // Result register with a one-entry skid: a result can still arrive from
    // the convolver pipeline in the first cycle res_ready is held low.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            ce_d       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (abort_hit) begin
            ce_d       <= 1'b0;
            res_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            ce_d <= conv_ce;
            if (res_valid) begin
                if (res_ready) begin
                    if (skid_valid) begin
                        res_data   <= skid_data;
                        skid_valid <= capture;
                        if (capture) skid_data <= conv_op;
                    end else if (capture) begin
                        res_data <= conv_op;
                    end else begin
                        res_valid <= 1'b0;
                    end
                end else if (capture) begin
                    skid_valid <= 1'b1;
                    skid_data  <= conv_op;
                end
            end else if (capture) begin
                res_valid <= 1'b1;
                res_data  <= conv_op;
            end
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // Saturating streaming-cycle and input-stall counters, cleared on start.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (((state_q == STREAM) || (state_q == DRAIN)) && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'(1);
            end
            if ((state_q == STREAM) && act_valid && !act_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench for conv_sequencer with a behavioural
// KxK convolver model feeding a result scoreboard.
module tb_conv_sequencer;

    localparam int unsigned N    = 10;
    localparam int unsigned K    = 3;
    localparam int unsigned DW   = 16;
    localparam int unsigned TAPS = K * K;
    localparam int unsigned NRES = (N - K + 1) * (N - K + 1);

    logic              clk = 1'b0;
    logic              global_rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              wt_valid = 1'b0;
    logic              wt_ready;
    logic [DW-1:0]     wt_data = '0;
    logic              act_valid = 1'b0;
    logic              act_ready;
    logic [DW-1:0]     act_data = '0;
    logic              conv_ce;
    logic              conv_rst;
    logic [DW-1:0]     conv_act;
    logic [TAPS*DW-1:0] conv_wt;
    logic [DW-1:0]     conv_op = '0;
    logic              conv_valid = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [DW-1:0]     res_data;
    logic              busy;
    logic              done;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stalls;
`endif

    always #5 clk = ~clk;

    conv_sequencer #(.N(N), .K(K), .DW(DW)) dut (
        .clk(clk), .global_rst_n(global_rst_n), .start(start), .abort(abort),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .conv_ce(conv_ce), .conv_rst(conv_rst), .conv_act(conv_act), .conv_wt(conv_wt),
        .conv_op(conv_op), .conv_valid(conv_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Convolver model: registered result for the pixel clocked in by conv_ce.
    logic [DW-1:0] img [N*N];
    int            mp = 0;
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) begin : conv_model
        int r;
        int c;
        logic [DW-1:0] acc;
        if (!global_rst_n || conv_rst) begin
            mp         <= 0;
            conv_valid <= 1'b0;
        end else if (conv_ce) begin
            r = mp / N;
            c = mp % N;
            img[mp] = conv_act;
            if ((r >= K - 1) && (c >= K - 1)) begin
                acc = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc = acc + conv_wt[(i*K+j)*DW +: DW] * img[(r-K+1+i)*N + (c-K+1+j)];
                conv_op    <= acc;
                conv_valid <= 1'b1;
                exp_q.push_back(acc);
            end else begin
                conv_valid <= 1'b0;
            end
            mp <= mp + 1;
        end else begin
            conv_valid <= 1'b0;
        end
    end

    // Result monitor on the falling edge.
    int            res_seen = 0;
    int            done_seen = 0;
    int            res_sum = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin : res_monitor
        logic [DW-1:0] e;
        if (global_rst_n && !abort) begin
            if (done) done_seen++;
            check("ce_eq", 256'(conv_ce), 256'(act_valid & act_ready));
            if (prev_hold) begin
                check("hold_valid", 256'(res_valid), 256'(1));
                check("hold_data", 256'(res_data), 256'(prev_data));
            end
            if (res_valid && !res_ready) check("stall_act_ready", 256'(act_ready), 256'(0));
            if (res_valid && res_ready) begin
                check("sb_nonempty", 256'(exp_q.size() != 0), 256'(1));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("sb_data", 256'(res_data), 256'(e));
                res_seen++;
                res_sum += int'(res_data);
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // res_ready driver: constant 1 or alternating.
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0) res_ready = ~res_ready;
            else                 res_ready = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAPS*DW-1:0] mk_wts(input int a, input int b);
        logic [TAPS*DW-1:0] v;
        for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'(a + b * i);
        return v;
    endfunction

    task automatic load_weights(input logic [TAPS*DW-1:0] wts);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("busy_after_start", 256'(busy), 256'(1));
        check("wt_ready_load", 256'(wt_ready), 256'(1));
        for (int i = 0; i < TAPS; i++) begin
            wt_valid = 1'b1;
            wt_data  = wts[i*DW +: DW];
            step();
        end
        wt_valid = 1'b0;
        #1;
        check("conv_rst_clear", 256'(conv_rst), 256'(1));
        check("wt_ready_clear", 256'(wt_ready), 256'(0));
        check("conv_wt_loaded", 256'(conv_wt), 256'(wts));
        step();
        #1;
        check("conv_rst_stream", 256'(conv_rst), 256'(0));
        check("act_ready_stream", 256'(act_ready), 256'(1));
    endtask

    task automatic stream(input int gap, input int pmode, input int abort_at,
                          input int poke_at, output bit aborted);
        int p = 0;
        int cyc = 0;
        bit poked = 1'b0;
        aborted = 1'b0;
        while (p < N * N && cyc < 5000) begin
            act_valid = (gap == 0) || (cyc % (gap + 1) == 0);
            act_data  = (pmode != 0) ? DW'(p % 5 + 1) : DW'(1);
            abort     = (p == abort_at);
            start     = 1'b0;
            wt_valid  = 1'b0;
            if (p == poke_at && !poked) begin
                start    = 1'b1;
                wt_valid = 1'b1;
                wt_data  = 16'hdead;
                poked    = 1'b1;
            end
            #1;
            if (start) check("wt_ready_stream", 256'(wt_ready), 256'(0));
            if (abort) begin
                step();
                abort     = 1'b0;
                act_valid = 1'b0;
                #1;
                check("abort_conv_rst", 256'(conv_rst), 256'(1));
                check("abort_busy", 256'(busy), 256'(0));
                check("abort_act_ready", 256'(act_ready), 256'(0));
                step();
                #1;
                check("abort_rst_pulse", 256'(conv_rst), 256'(0));
                aborted = 1'b1;
                return;
            end
            if (act_valid && act_ready) p++;
            step();
            cyc++;
        end
        act_valid = 1'b0;
        start     = 1'b0;
        wt_valid  = 1'b0;
        check("stream_bound", 256'(cyc < 5000), 256'(1));
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_seen == d0 && n < 2000) begin
            step();
            n++;
        end
        check("done_bound", 256'(n < 2000), 256'(1));
    endtask

    task automatic run_frame(input logic [TAPS*DW-1:0] wts, input int gap, input int pmode,
                             input int rmode, input int poke_at);
        int d0;
        bit ab;
        res_seen   = 0;
        res_sum    = 0;
        d0         = done_seen;
        ready_mode = rmode;
        load_weights(wts);
        stream(gap, pmode, -1, poke_at, ab);
        wait_done(d0);
        repeat (3) step();
        ready_mode = 0;
        check("res_count", 256'(res_seen), 256'(NRES));
        check("done_count", 256'(done_seen), 256'(d0 + 1));
        check("busy_idle", 256'(busy), 256'(0));
        check("sb_drained", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        logic [TAPS*DW-1:0] w3;
        int d0;
        bit ab;

        // Reset with live-looking inputs.
        wt_valid  = 1'b1;
        wt_data   = 16'h1234;
        act_valid = 1'b1;
        act_data  = 16'h0055;
        repeat (3) step();
        #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_wt_ready", 256'(wt_ready), 256'(0));
        check("rst_act_ready", 256'(act_ready), 256'(0));
        check("rst_conv_ce", 256'(conv_ce), 256'(0));
        check("rst_conv_rst", 256'(conv_rst), 256'(1));
        check("rst_res_valid", 256'(res_valid), 256'(0));
        check("rst_res_data", 256'(res_data), 256'(0));
        check("rst_conv_wt", 256'(conv_wt), 256'(0));
        check("conv_act_pass", 256'(conv_act), 256'(16'h0055));
        global_rst_n = 1'b1;
        wt_valid     = 1'b0;
        act_valid    = 1'b0;
        step();
        #1;
        check("idle_conv_rst", 256'(conv_rst), 256'(0));
        check("idle_busy", 256'(busy), 256'(0));

        // Weights 1..9, unit pixels: every result is 45.
        run_frame(mk_wts(1, 1), 0, 0, 0, -1);
        check("sum_frame1", 256'(res_sum), 256'(NRES * 45));

        // Alternating res_ready with varied pixels.
        run_frame(mk_wts(2, 3), 0, 1, 1, -1);

        // start and wt_valid poked mid-stream are ignored.
        w3 = mk_wts(9, -1);
        run_frame(w3, 0, 0, 0, 20);
        check("conv_wt_kept", 256'(conv_wt), 256'(w3));
        check("sum_frame3", 256'(res_sum), 256'(NRES * 45));

        // Abort at pixel 30, then a full frame.
        d0 = done_seen;
        load_weights(mk_wts(1, 1));
        stream(0, 0, 30, -1, ab);
        check("abort_taken", 256'(ab), 256'(1));
        repeat (5) step();
        check("abort_no_done", 256'(done_seen), 256'(d0));
        check("abort_res_valid", 256'(res_valid), 256'(0));
        check("abort_idle", 256'(busy), 256'(0));
        exp_q.delete();
        run_frame(mk_wts(1, 1), 0, 0, 0, -1);
        check("sum_after_abort", 256'(res_sum), 256'(NRES * 45));

        // Reset while draining.
        d0 = done_seen;
        load_weights(mk_wts(1, 1));
        stream(0, 0, -1, -1, ab);
        check("drain_busy", 256'(busy), 256'(1));
        global_rst_n = 1'b0;
        act_valid    = 1'b1;
        step();
        #1;
        check("drst_busy", 256'(busy), 256'(0));
        check("drst_done", 256'(done), 256'(0));
        check("drst_res_valid", 256'(res_valid), 256'(0));
        check("drst_res_data", 256'(res_data), 256'(0));
        check("drst_conv_rst", 256'(conv_rst), 256'(1));
        check("drst_wt_ready", 256'(wt_ready), 256'(0));
        check("drst_act_ready", 256'(act_ready), 256'(0));
        check("drst_conv_ce", 256'(conv_ce), 256'(0));
        check("drst_conv_wt", 256'(conv_wt), 256'(0));
        global_rst_n = 1'b1;
        act_valid    = 1'b0;
        repeat (30) step();
        check("drst_no_done", 256'(done_seen), 256'(d0));
        check("drst_idle", 256'(busy), 256'(0));
        exp_q.delete();

`ifdef CONV_SEQ_PERF_EN
        // Sparse input: gaps of 5 idle cycles between pixels.
        run_frame(mk_wts(1, 1), 5, 0, 0, -1);
        check("perf_stalls", 256'(perf_stalls), 256'(0));
        check("perf_cycles_gt100", 256'(perf_cycles > 32'd100), 256'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
